// File: rtl/fog_ctrl_pkg.sv
// Shared types for the FOG control sequencer: FSM states, register map and the
// configuration register bundle used for both shadow and active copies.
package fog_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACQ    = 2'd2,
    RUN    = 2'd3
  } ctrl_state_t;

  localparam logic [ADDR_W-1:0] ADDR_FREQ  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_AMPH  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_AMPL  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_POL   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_WAIT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_EOFS  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_AVG   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_CSTEP = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] ADDR_GSTEP = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_GRAMP = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ADDR_FBEN  = ADDR_W'(10);

  typedef struct packed {
    logic [DATA_W-1:0] freq_cnt;
    logic [DATA_W-1:0] amp_h;
    logic [DATA_W-1:0] amp_l;
    logic              polarity;
    logic [DATA_W-1:0] wait_cnt;
    logic [DATA_W-1:0] err_offset;
    logic [DATA_W-1:0] avg_sel;
    logic [DATA_W-1:0] const_step;
    logic [DATA_W-1:0] gain_sel_step;
    logic [DATA_W-1:0] gain_sel_ramp;
    logic              fb_enable;
  } cfg_regs_t;

  // Power-on contents of a register bank; feedback is enabled by default.
  function automatic cfg_regs_t cfg_defaults(input logic [DATA_W-1:0] freq,
                                             input logic [DATA_W-1:0] wait_c,
                                             input logic [DATA_W-1:0] gstep,
                                             input logic [DATA_W-1:0] gramp);
    cfg_regs_t r;
    r               = '0;
    r.freq_cnt      = freq;
    r.wait_cnt      = wait_c;
    r.gain_sel_step = gstep;
    r.gain_sel_ramp = gramp;
    r.fb_enable     = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fog_cfg_shadow.sv
// CPU-facing shadow register bank with a commit that transfers shadow to active
// only on a modulation switching trigger.
module fog_cfg_shadow
  import fog_ctrl_pkg::*;
#(
  parameter int unsigned RST_FREQ_CNT  = 100,
  parameter int unsigned RST_WAIT_CNT  = 20,
  parameter int unsigned RST_GAIN_STEP = 10,
  parameter int unsigned RST_GAIN_RAMP = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic              step_trig,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              commit_pend,
  output logic              fb_enable,
  output cfg_regs_t         active_nxt_c
);

  localparam cfg_regs_t RST_REGS = cfg_defaults(DATA_W'(RST_FREQ_CNT), DATA_W'(RST_WAIT_CNT),
                                                DATA_W'(RST_GAIN_STEP), DATA_W'(RST_GAIN_RAMP));

  cfg_regs_t shadow_q, shadow_d, active_q;
  logic      wr_en, load, pend_d, err_d;

  assign wr_en     = cfg_valid && cfg_ready;
  assign load      = commit_pend && step_trig;
  assign fb_enable = active_q.fb_enable;

  // Write decode, commit bookkeeping and next active value.
  always_comb begin
    shadow_d     = shadow_q;
    err_d        = 1'b0;
    pend_d       = commit_pend;
    active_nxt_c = active_q;
    if (wr_en) begin
      case (cfg_addr)
        ADDR_FREQ:  shadow_d.freq_cnt      = cfg_data;
        ADDR_AMPH:  shadow_d.amp_h         = cfg_data;
        ADDR_AMPL:  shadow_d.amp_l         = cfg_data;
        ADDR_POL:   shadow_d.polarity      = cfg_data[0];
        ADDR_WAIT:  shadow_d.wait_cnt      = cfg_data;
        ADDR_EOFS:  shadow_d.err_offset    = cfg_data;
        ADDR_AVG:   shadow_d.avg_sel       = cfg_data;
        ADDR_CSTEP: shadow_d.const_step    = cfg_data;
        ADDR_GSTEP: shadow_d.gain_sel_step = cfg_data;
        ADDR_GRAMP: shadow_d.gain_sel_ramp = cfg_data;
        ADDR_FBEN:  shadow_d.fb_enable     = cfg_data[0];
        default:    err_d                  = 1'b1;
      endcase
    end
    // A commit raised while one is pending is dropped; the trigger that
    // transfers also clears the pending flag.
    if (load) begin
      pend_d       = 1'b0;
      active_nxt_c = shadow_q;
    end else if (cfg_commit) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= RST_REGS;
      active_q    <= RST_REGS;
      commit_pend <= 1'b0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_nxt_c;
      commit_pend <= pend_d;
      cfg_ready   <= !pend_d;
      cfg_err     <= err_d;
    end
  end

endmodule

// File: rtl/fog_ctrl_sequencer.sv
// FOG loop-closure sequencer: settle, high-gain acquisition and run, driving the
// committed configuration to the datapath with modulation gated in IDLE.
module fog_ctrl_sequencer
  import fog_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC    = 1024,
  parameter int unsigned ACQ_STEPS     = 4096,
  parameter int unsigned ACQ_SHIFT     = 3,
  parameter int unsigned RST_FREQ_CNT  = 100,
  parameter int unsigned RST_WAIT_CNT  = 20,
  parameter int unsigned RST_GAIN_STEP = 10,
  parameter int unsigned RST_GAIN_RAMP = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [3:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_data,
  input  logic        i_cfg_commit,
  output logic        o_cfg_err,
  input  logic        i_step_trig,
  input  logic        i_step_sync,
  output logic [31:0] o_freq_cnt,
  output logic [31:0] o_amp_H,
  output logic [31:0] o_amp_L,
  output logic [31:0] o_wait_cnt,
  output logic [31:0] o_err_offset,
  output logic [31:0] o_avg_sel,
  output logic [31:0] o_const_step,
  output logic [31:0] o_gainSel_step,
  output logic [31:0] o_gainSel_ramp,
  output logic        o_polarity,
  output logic        o_fb_ON,
  output logic [1:0]  o_state,
  output logic        o_commit_pend
);

  cfg_regs_t         active_nxt;
  logic              fb_enable;
  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  fog_cfg_shadow #(
    .RST_FREQ_CNT (RST_FREQ_CNT),
    .RST_WAIT_CNT (RST_WAIT_CNT),
    .RST_GAIN_STEP(RST_GAIN_STEP),
    .RST_GAIN_RAMP(RST_GAIN_RAMP)
  ) u_shadow (
    .clk         (i_clk),
    .rst         (i_rst),
    .cfg_valid   (i_cfg_valid),
    .cfg_addr    (i_cfg_addr),
    .cfg_data    (i_cfg_data),
    .cfg_commit  (i_cfg_commit),
    .step_trig   (i_step_trig),
    .cfg_ready   (o_cfg_ready),
    .cfg_err     (o_cfg_err),
    .commit_pend (o_commit_pend),
    .fb_enable   (fb_enable),
    .active_nxt_c(active_nxt)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Smaller select means larger gain; clamp at zero instead of wrapping.
  function automatic logic [DATA_W-1:0] gain_acq(input logic [DATA_W-1:0] g);
    return (g > DATA_W'(ACQ_SHIFT)) ? g - DATA_W'(ACQ_SHIFT) : '0;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; stop overrides start and any terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          cnt_d = sat_inc(cnt_q, i_step_trig);
          if ((cnt_d >= CNT_W'(SETTLE_CYC)) && fb_enable) begin
            state_d = ACQ;
            cnt_d   = '0;
          end
        end
        ACQ: begin
          cnt_d = sat_inc(cnt_q, i_step_sync);
          if (cnt_d >= CNT_W'(ACQ_STEPS)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (!fb_enable) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_state = state_q;

  // Datapath outputs track the incoming state and active values so they move
  // together with o_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_freq_cnt     <= DATA_W'(RST_FREQ_CNT);
      o_amp_H        <= '0;
      o_amp_L        <= '0;
      o_wait_cnt     <= DATA_W'(RST_WAIT_CNT);
      o_err_offset   <= '0;
      o_avg_sel      <= '0;
      o_const_step   <= '0;
      o_gainSel_step <= DATA_W'(RST_GAIN_STEP);
      o_gainSel_ramp <= DATA_W'(RST_GAIN_RAMP);
      o_polarity     <= 1'b0;
      o_fb_ON        <= 1'b0;
    end else begin
      o_freq_cnt     <= active_nxt.freq_cnt;
      o_amp_H        <= (state_d == IDLE) ? '0 : active_nxt.amp_h;
      o_amp_L        <= (state_d == IDLE) ? '0 : active_nxt.amp_l;
      o_wait_cnt     <= active_nxt.wait_cnt;
      o_err_offset   <= active_nxt.err_offset;
      o_avg_sel      <= active_nxt.avg_sel;
      o_const_step   <= active_nxt.const_step;
      o_gainSel_step <= (state_d == ACQ) ? gain_acq(active_nxt.gain_sel_step)
                                         : active_nxt.gain_sel_step;
      o_gainSel_ramp <= (state_d == ACQ) ? gain_acq(active_nxt.gain_sel_ramp)
                                         : active_nxt.gain_sel_ramp;
      o_polarity     <= active_nxt.polarity;
      o_fb_ON        <= (state_d == ACQ) || (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_fog_ctrl_sequencer.sv
// Bench for fog_ctrl_sequencer: vector table, directed sequence corners and a
// random run against a register-array reference model.
module tb_fog_ctrl_sequencer;

  localparam int unsigned SETTLE_N = 4;
  localparam int unsigned ACQ_N    = 8;
  localparam int unsigned SHIFT    = 3;

  typedef struct packed {
    logic        valid;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        commit;
    logic        trig;
    logic        sync;
    logic        start;
    logic        stop;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] freq;
    logic [31:0] amp_h;
    logic        ready;
    logic        pend;
    logic        err;
    logic        fb;
    logic [1:0]  st;
  } vec_t;

  typedef int unsigned regs_t [11];

  logic        clk = 1'b0;
  logic        rst, start, stop, cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        step_trig, step_sync;
  logic [31:0] freq_cnt, amp_h, amp_l, wait_cnt, err_offset, avg_sel, const_step;
  logic [31:0] gain_step, gain_ramp;
  logic        polarity, fb_on, commit_pend;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  regs_t           m_sh, m_act;
  bit              m_pend, m_err;
  int unsigned     m_state;
  longint unsigned m_cnt;

  vec_t vecs [10];

  always #5 clk = ~clk;

  fog_ctrl_sequencer #(
    .SETTLE_CYC(SETTLE_N),
    .ACQ_STEPS (ACQ_N),
    .ACQ_SHIFT (SHIFT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_ready   (cfg_ready),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .i_cfg_commit  (cfg_commit),
    .o_cfg_err     (cfg_err),
    .i_step_trig   (step_trig),
    .i_step_sync   (step_sync),
    .o_freq_cnt    (freq_cnt),
    .o_amp_H       (amp_h),
    .o_amp_L       (amp_l),
    .o_wait_cnt    (wait_cnt),
    .o_err_offset  (err_offset),
    .o_avg_sel     (avg_sel),
    .o_const_step  (const_step),
    .o_gainSel_step(gain_step),
    .o_gainSel_ramp(gain_ramp),
    .o_polarity    (polarity),
    .o_fb_ON       (fb_on),
    .o_state       (state),
    .o_commit_pend (commit_pend)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic stim_t f_idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t f_wr(input logic [3:0] a, input logic [31:0] d);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.addr  = a;
    s.data  = d;
    return s;
  endfunction

  function automatic stim_t f_ctl(input logic c, input logic t, input logic y,
                                  input logic go, input logic halt);
    stim_t s;
    s        = '0;
    s.commit = c;
    s.trig   = t;
    s.sync   = y;
    s.start  = go;
    s.stop   = halt;
    return s;
  endfunction

  function automatic int unsigned gsub(input int unsigned g);
    return (g > SHIFT) ? g - SHIFT : 0;
  endfunction

  task automatic model_reset();
    m_sh    = '{100, 0, 0, 0, 20, 0, 0, 0, 10, 10, 1};
    m_act   = m_sh;
    m_pend  = 0;
    m_err   = 0;
    m_state = 0;
    m_cnt   = 0;
  endtask

  // Behaviour of one clock: shadow write, commit transfer, sequencer mode.
  task automatic model_step(input stim_t s);
    regs_t           n_sh, n_act;
    bit              n_pend, n_err, fb;
    int unsigned     n_state;
    longint unsigned n_cnt;
    int              idx;
    n_sh    = m_sh;
    n_act   = m_act;
    n_pend  = m_pend;
    n_err   = 0;
    n_state = m_state;
    n_cnt   = m_cnt;
    fb      = (m_act[10] & 1) != 0;
    idx     = int'(s.addr);
    if (s.valid && !m_pend) begin
      if (idx <= 10) n_sh[idx] = (idx == 3 || idx == 10) ? (s.data & 32'd1) : s.data;
      else n_err = 1;
    end
    if (m_pend && s.trig) begin
      n_act  = m_sh;
      n_pend = 0;
    end else if (s.commit) begin
      n_pend = 1;
    end
    if (s.stop) begin
      n_state = 0;
      n_cnt   = 0;
    end else if (m_state == 0) begin
      if (s.start) begin n_state = 1; n_cnt = 0; end
    end else if (m_state == 1) begin
      n_cnt = (m_cnt + longint'(s.trig) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + longint'(s.trig);
      if (n_cnt >= SETTLE_N && fb) begin n_state = 2; n_cnt = 0; end
    end else if (m_state == 2) begin
      n_cnt = (m_cnt + longint'(s.sync) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + longint'(s.sync);
      if (n_cnt >= ACQ_N) begin n_state = 3; n_cnt = 0; end
    end else begin
      if (!fb) begin n_state = 1; n_cnt = 0; end
    end
    m_sh    = n_sh;
    m_act   = n_act;
    m_pend  = n_pend;
    m_err   = n_err;
    m_state = n_state;
    m_cnt   = n_cnt;
  endtask

  task automatic check_model();
    bit closed;
    closed = (m_state == 2) || (m_state == 3);
    chk("state",        32'(state),       m_state);
    chk("fb_ON",        32'(fb_on),       32'(closed));
    chk("freq_cnt",     freq_cnt,         m_act[0]);
    chk("amp_H",        amp_h,            (m_state == 0) ? 32'd0 : m_act[1]);
    chk("amp_L",        amp_l,            (m_state == 0) ? 32'd0 : m_act[2]);
    chk("polarity",     32'(polarity),    m_act[3]);
    chk("wait_cnt",     wait_cnt,         m_act[4]);
    chk("err_offset",   err_offset,       m_act[5]);
    chk("avg_sel",      avg_sel,          m_act[6]);
    chk("const_step",   const_step,       m_act[7]);
    chk("gainSel_step", gain_step,        (m_state == 2) ? gsub(m_act[8]) : m_act[8]);
    chk("gainSel_ramp", gain_ramp,        (m_state == 2) ? gsub(m_act[9]) : m_act[9]);
    chk("cfg_ready",    32'(cfg_ready),   32'(!m_pend));
    chk("commit_pend",  32'(commit_pend), 32'(m_pend));
    chk("cfg_err",      32'(cfg_err),     32'(m_err));
  endtask

  task automatic drive(input stim_t s);
    cfg_valid  = s.valid;
    cfg_addr   = s.addr;
    cfg_data   = s.data;
    cfg_commit = s.commit;
    step_trig  = s.trig;
    step_sync  = s.sync;
    start      = s.start;
    stop       = s.stop;
  endtask

  // Called at a falling edge: apply inputs, clock once, compare at next fall.
  task automatic cycle(input stim_t s);
    drive(s);
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    drive(f_idle());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();
    chk("rst_freq",  freq_cnt,        32'd100);
    chk("rst_wait",  wait_cnt,        32'd20);
    chk("rst_gstep", gain_step,       32'd10);
    chk("rst_gramp", gain_ramp,       32'd10);
    chk("rst_ready", 32'(cfg_ready),  32'd1);
    chk("rst_state", 32'(state),      32'd0);

    // Commit window: commit on a trigger waits for the next one; writes blocked while pending.
    vecs[0] = '{f_wr(4'd0, 32'd200),       32'd100, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{f_wr(4'd1, 32'h55),        32'd100, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{f_ctl(1, 1, 0, 0, 0),      32'd100, 32'd0,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3] = '{f_idle(),                  32'd100, 32'd0,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4] = '{f_wr(4'd2, 32'd7),         32'd100, 32'd0,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5] = '{f_ctl(0, 1, 0, 0, 0),      32'd200, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[6] = '{f_wr(4'd13, 32'd9),        32'd200, 32'd0,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[7] = '{f_idle(),                  32'd200, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8] = '{f_ctl(0, 0, 0, 1, 0),      32'd200, 32'h55,   1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[9] = '{f_ctl(0, 0, 0, 1, 1),      32'd200, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].s);
      chk($sformatf("vec%0d_freq", i),  freq_cnt,          vecs[i].freq);
      chk($sformatf("vec%0d_ampH", i),  amp_h,             vecs[i].amp_h);
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready),    32'(vecs[i].ready));
      chk($sformatf("vec%0d_pend", i),  32'(commit_pend),  32'(vecs[i].pend));
      chk($sformatf("vec%0d_err", i),   32'(cfg_err),      32'(vecs[i].err));
      chk($sformatf("vec%0d_fb", i),    32'(fb_on),        32'(vecs[i].fb));
      chk($sformatf("vec%0d_state", i), 32'(state),        32'(vecs[i].st));
    end

    // Full closure: settle for 4 triggers, acquire for 8 syncs, run.
    cycle(f_ctl(0, 0, 0, 1, 0));
    chk("seq_settle", 32'(state), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(f_ctl(0, 1, 0, 0, 0));
      cycle(f_idle());
    end
    chk("seq_settle_hold", 32'(state), 32'd1);
    cycle(f_ctl(0, 1, 0, 0, 0));
    chk("seq_acq_state", 32'(state),  32'd2);
    chk("seq_acq_fb",    32'(fb_on),  32'd1);
    chk("seq_acq_gain",  gain_step,   32'd7);
    for (int k = 0; k < 7; k++) begin
      cycle(f_ctl(0, 0, 1, 0, 0));
      cycle(f_idle());
    end
    chk("seq_acq_hold", 32'(state), 32'd2);
    cycle(f_ctl(0, 0, 1, 0, 0));
    chk("seq_run_state", 32'(state), 32'd3);
    chk("seq_run_gain",  gain_step,  32'd10);

    // Drop feedback from RUN, then re-enable inside SETTLE.
    cycle(f_wr(4'd8, 32'd1));
    cycle(f_wr(4'd10, 32'd0));
    cycle(f_ctl(1, 0, 0, 0, 0));
    cycle(f_idle());
    cycle(f_ctl(0, 1, 0, 0, 0));
    chk("fboff_still_run", 32'(state), 32'd3);
    chk("fboff_gain",      gain_step,  32'd1);
    cycle(f_idle());
    chk("fboff_state", 32'(state), 32'd1);
    chk("fboff_fb",    32'(fb_on), 32'd0);
    cycle(f_wr(4'd10, 32'd1));
    cycle(f_ctl(1, 0, 0, 0, 0));
    cycle(f_idle());
    cycle(f_ctl(0, 1, 0, 0, 0));
    cycle(f_idle());
    cycle(f_ctl(0, 1, 0, 0, 0));
    cycle(f_ctl(0, 1, 0, 0, 0));
    chk("reen_settle", 32'(state), 32'd1);
    cycle(f_ctl(0, 1, 0, 0, 0));
    chk("reen_acq",     32'(state), 32'd2);
    chk("sat_gstep",    gain_step,  32'd0);
    chk("sat_gramp",    gain_ramp,  32'd7);
    chk("acq_amp",      amp_h,      32'h55);

    // Stop wins over start and the acquisition terminal count.
    for (int k = 0; k < 7; k++) begin
      cycle(f_ctl(0, 0, 1, 0, 0));
      cycle(f_idle());
    end
    cycle(f_ctl(0, 0, 1, 1, 1));
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_amp",   amp_h,      32'd0);
    chk("stop_fb",    32'(fb_on), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      s        = '0;
      s.valid  = ($urandom_range(0, 5) == 0);
      s.addr   = 4'($urandom_range(0, 15));
      s.data   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : 32'($urandom);
      s.commit = ($urandom_range(0, 19) == 0);
      s.trig   = ($urandom_range(0, 5) == 0);
      s.sync   = ($urandom_range(0, 2) == 0);
      s.start  = ($urandom_range(0, 29) == 0);
      s.stop   = ($urandom_range(0, 299) == 0);
      cycle(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fog_ctrl_sequencer.md
Name: fog_ctrl_sequencer

Overview:
- Configuration and start-up sequencer for the FOG closed-loop datapath (modulation gen, error gen, feedback step gen, phase ramp gen).
- Holds CPU-written shadow registers and commits them atomically on a modulation half-cycle boundary, so the datapath never sees a mid-cycle parameter change.
- Runs the loop-closure sequence: modulation settle, high-gain acquisition, then normal run.
- Sits between the CPU register bus and the var_* inputs of the FOG top.

Parameters:
- SETTLE_CYC, 1024: number of i_step_trig pulses spent open-loop before feedback is enabled.
- ACQ_STEPS, 4096: number of i_step_sync pulses spent in high-gain acquisition.
- ACQ_SHIFT, 3: amount subtracted from the gainSel values during acquisition (smaller select = larger gain).
- RST_FREQ_CNT, 100: reset value of freq_cnt.
- RST_WAIT_CNT, 20: reset value of wait_cnt.
- RST_GAIN_STEP, 10: reset value of gainSel_step.
- RST_GAIN_RAMP, 10: reset value of gainSel_ramp.

Ports:
- i_clk in 1: DAC-domain clock.
- i_rst in 1: synchronous reset, active-high.
- i_start in 1: pulse; begin the sequence from IDLE.
- i_stop in 1: pulse; return to IDLE.
- i_cfg_valid in 1: config write request.
- o_cfg_ready out 1: write accepted when valid&ready.
- i_cfg_addr in 4: shadow register index.
- i_cfg_data in 32: write data.
- i_cfg_commit in 1: pulse; request shadow-to-active transfer.
- o_cfg_err out 1: one-cycle pulse on a write to an unmapped address.
- i_step_trig in 1: modulation switching trigger from the modulation generator.
- i_step_sync in 1: feedback trigger from the error generator.
- o_freq_cnt, o_amp_H, o_amp_L, o_wait_cnt, o_err_offset, o_avg_sel, o_const_step, o_gainSel_step, o_gainSel_ramp out 32 each: active values driven to the datapath.
- o_polarity out 1: active polarity.
- o_fb_ON out 1: feedback enable.
- o_state out 2: 0 IDLE, 1 SETTLE, 2 ACQ, 3 RUN.
- o_commit_pend out 1: commit waiting for a boundary.

Behaviour:
- Clock and reset: all state on i_clk. i_rst is synchronous, active-high.
- Reset values:
  - shadow and active regs: freq_cnt=RST_FREQ_CNT, wait_cnt=RST_WAIT_CNT, gainSel_step=RST_GAIN_STEP, gainSel_ramp=RST_GAIN_RAMP, all others 0.
  - fb_enable=1.
  - state IDLE, counters 0, o_fb_ON=0, o_commit_pend=0, o_cfg_err=0, o_cfg_ready=1.
- Address map: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 polarity (bit0), 4 wait_cnt, 5 err_offset, 6 avg_sel, 7 const_step, 8 gainSel_step, 9 gainSel_ramp, 10 fb_enable (bit0).
  - Addr 11-15: write is accepted, no register changes, o_cfg_err pulses on the next cycle.
- Write handshake: a write takes effect in the shadow register on the cycle valid&ready is true. o_cfg_ready = !commit_pend.
- Commit:
  - i_cfg_commit sets commit_pend.
  - On the first i_step_trig strictly after the cycle commit_pend became set, all active regs load from shadow and commit_pend clears. Active regs change one cycle after that trigger.
  - A commit on the same cycle as i_step_trig waits for the next trigger.
  - A commit while already pending is ignored.
- Outputs in IDLE: o_amp_H=o_amp_L=0 (modulation off) and o_fb_ON=0. All other outputs show the active regs.
- FSM:
  - IDLE -> SETTLE on i_start; clear the counter.
  - SETTLE: amps active, fb off, count i_step_trig. When the count reaches SETTLE_CYC and fb_enable=1, go to ACQ and clear the counter. If fb_enable=0, hold in SETTLE.
  - ACQ: o_fb_ON=1; o_gainSel_step and o_gainSel_ramp = active minus ACQ_SHIFT, saturating at 0; count i_step_sync. When the count reaches ACQ_STEPS, go to RUN.
  - RUN: o_fb_ON=1, gains taken from the active regs. If fb_enable is committed to 0, go to SETTLE with the counter cleared.
- i_stop in any state: IDLE on the next cycle, o_fb_ON low one cycle after i_stop. i_stop takes priority over i_start and over any counter terminal event in the same cycle.
- i_start outside IDLE is ignored.
- Counters are 32-bit and saturate; they never wrap.
- Outputs are registered; FSM-driven outputs change the cycle after the state transition.

Decomposition:
- Package fog_ctrl_pkg holds:
  - state enum ctrl_state_t {IDLE, SETTLE, ACQ, RUN};
  - address localparams ADDR_FREQ..ADDR_FBEN;
  - cfg_regs_t struct covering all 11 registers, used for both shadow and active copies.
- One sub-module, fog_cfg_shadow: shadow regs, write decode, o_cfg_err, commit_pend and boundary transfer.
- FSM and gain adjustment stay in the top.

Test Plan:
- Reset, then write addr0=200 and commit, with i_step_trig every 50 cycles -> o_freq_cnt stays 100 until the cycle after the first trig following the commit, then becomes 200. o_cfg_ready is low during the pending window.
- i_start with SETTLE_CYC=4, ACQ_STEPS=8, gainSel_step=10 -> o_state goes 1 for 4 trigs, then 2 with o_fb_ON=1 and o_gainSel_step=7, then 3 after 8 i_step_sync with o_gainSel_step=10.
- gainSel_step=1 in ACQ -> o_gainSel_step=0 (saturated, no underflow).
- In RUN, commit fb_enable=0 -> o_state=1 and o_fb_ON=0 after the boundary. Re-enable -> ACQ after 4 trigs.
- i_stop, i_start and a counter terminal event in the same cycle -> IDLE, o_amp_H=0, o_fb_ON=0.
- Write addr13 -> o_cfg_err pulses once and all shadow and active values are unchanged.
